prs_ber_checker: RTL and testbench



---
 rtl/prs_ber_checker.sv | 161 ++++++++++++++++
 tb/tb_prs_ber_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prs_ber_checker.sv
// prs_ber_checker: BER monitor for a decoded PRBS-15 (x^15+x^14+1) bit stream.
// It synchronises a local PRBS replica to the incoming bits. Once locked, it counts
// bit errors over windows of 2^WIN_W valid bits and keeps saturating totals.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   i_clear               sync clear of window and totals (lock state kept)
//   i_vld, i_sym          decoded bit strobe and bit value
//   o_locked              replica locked to the stream
//   o_win_vld, o_win_err  one-cycle pulse with the error count of the completed window
//   o_tot_err, o_tot_bits saturating error / bit totals since lock or clear
module prs_ber_checker #(
  parameter int unsigned WIN_W    = 10,
  parameter int unsigned LOCK_THR = 64,
  parameter int unsigned LOSS_THR = 128,
  parameter int unsigned TOT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_vld,
  input  logic             i_sym,
  output logic             o_locked,
  output logic             o_win_vld,
  output logic [WIN_W:0]   o_win_err,
  output logic [TOT_W-1:0] o_tot_err,
  output logic [TOT_W-1:0] o_tot_bits
);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  localparam logic [15:0] LockThr = 16'(LOCK_THR);

  state_e           state_q, state_d;
  logic [14:0]      sr_q, sr_d;
  logic [3:0]       fill_q, fill_d;
  logic [15:0]      match_q, match_d;
  logic [WIN_W-1:0] win_bits_q, win_bits_d;
  logic [WIN_W:0]   win_cnt_q, win_cnt_d;
  logic             win_vld_q, win_vld_d;
  logic [WIN_W:0]   win_err_q, win_err_d;
  logic [TOT_W-1:0] tot_err_q, tot_err_d;
  logic [TOT_W-1:0] tot_bits_q, tot_bits_d;

  logic             pred;
  logic             err;
  logic             win_end;
  logic             win_over;
  logic [WIN_W:0]   win_cnt_inc;

  assign pred        = sr_q[14] ^ sr_q[13];
  assign err         = i_sym ^ pred;
  assign win_cnt_inc = win_cnt_q + {{WIN_W{1'b0}}, err};
  assign win_end     = (state_q == StLocked) && i_vld && (win_bits_q == {WIN_W{1'b1}});
  assign win_over    = 32'(win_cnt_inc) > 32'(LOSS_THR);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    match_d    = match_q;
    win_bits_d = win_bits_q;
    win_cnt_d  = win_cnt_q;
    win_vld_d  = 1'b0;
    win_err_d  = win_err_q;
    tot_err_d  = tot_err_q;
    tot_bits_d = tot_bits_q;

    case (state_q)
      StSearch: begin
        if (i_vld) begin
          sr_d = {sr_q[13:0], i_sym};
          if (fill_q != 4'd15) begin
            fill_d = fill_q + 4'd1;
          end else if (err) begin
            match_d = '0;
          end else if (match_q + 16'd1 == LockThr) begin
            state_d    = StLocked;
            match_d    = '0;
            win_bits_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
            tot_err_d  = '0;
            tot_bits_d = '0;
          end else begin
            match_d = match_q + 16'd1;
          end
        end
      end
      StLocked: begin
        if (i_vld) begin
          // Replica free-runs so channel errors never corrupt the prediction.
          sr_d       = {sr_q[13:0], pred};
          win_bits_d = win_bits_q + {{(WIN_W-1){1'b0}}, 1'b1};
          win_cnt_d  = win_cnt_inc;
          if (!(&tot_bits_q)) tot_bits_d = tot_bits_q + {{(TOT_W-1){1'b0}}, 1'b1};
          if (err && !(&tot_err_q)) tot_err_d = tot_err_q + {{(TOT_W-1){1'b0}}, 1'b1};
          if (win_end) begin
            win_vld_d = 1'b1;
            win_err_d = win_cnt_inc;
            win_cnt_d = '0;
            if (win_over) begin
              state_d = StSearch;
              fill_d  = '0;
              match_d = '0;
            end
          end
        end
      end
      default: state_d = StSearch;
    endcase

    // Clear wins over the current bit and any window end, but never undoes lock.
    if (i_clear) begin
      win_bits_d = '0;
      win_cnt_d  = '0;
      win_err_d  = '0;
      tot_err_d  = '0;
      tot_bits_d = '0;
      win_vld_d  = 1'b0;
      if (state_q == StLocked) begin
        state_d = StLocked;
        fill_d  = fill_q;
        match_d = match_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StSearch;
      sr_q       <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      win_bits_q <= '0;
      win_cnt_q  <= '0;
      win_vld_q  <= 1'b0;
      win_err_q  <= '0;
      tot_err_q  <= '0;
      tot_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      win_bits_q <= win_bits_d;
      win_cnt_q  <= win_cnt_d;
      win_vld_q  <= win_vld_d;
      win_err_q  <= win_err_d;
      tot_err_q  <= tot_err_d;
      tot_bits_q <= tot_bits_d;
    end
  end

  assign o_locked   = (state_q == StLocked);
  assign o_win_vld  = win_vld_q;
  assign o_win_err  = win_err_q;
  assign o_tot_err  = tot_err_q;
  assign o_tot_bits = tot_bits_q;

endmodule

// File: tb/tb_prs_ber_checker.sv
// Directed bench for prs_ber_checker: PRBS-15 stimulus with hand-computed expectations.
module tb_prs_ber_checker;

  localparam int WIN_W = 10;
  localparam int TOT_W = 32;

  // Stream modes: 0 clean, 1 invert lock-relative multiples of 128, 2 invert odd bits,
  // 3 invert every bit.
  typedef struct {
    int mode;
    int nbits;
    int gap;
    bit rst_first;
    bit exp_locked;
    int exp_pulses;
    int exp_win_err;
    int exp_tot_bits;
    int exp_tot_err;
  } row_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_clear;
  logic             i_vld;
  logic             i_sym;
  logic             o_locked;
  logic             o_win_vld;
  logic [WIN_W:0]   o_win_err;
  logic [TOT_W-1:0] o_tot_err;
  logic [TOT_W-1:0] o_tot_bits;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pulses  = 0;
  logic [14:0] lfsr    = 15'h5a3c;
  row_t        rows[5];

  prs_ber_checker #(
    .WIN_W(WIN_W), .LOCK_THR(64), .LOSS_THR(128), .TOT_W(TOT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (i_clear),
    .i_vld     (i_vld),
    .i_sym     (i_sym),
    .o_locked  (o_locked),
    .o_win_vld (o_win_vld),
    .o_win_err (o_win_err),
    .o_tot_err (o_tot_err),
    .o_tot_bits(o_tot_bits)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_win_vld === 1'b1) pulses <= pulses + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d tests %0d failed", n_tests,
             n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic prbs_next(output logic b);
    b    = lfsr[14] ^ lfsr[13];
    lfsr = {lfsr[13:0], b};
  endtask

  task automatic send_bit(input logic b, input logic clr, input int gap);
    @(negedge clk);
    i_vld   = 1'b1;
    i_sym   = b;
    i_clear = clr;
    @(posedge clk);
    #1;
    i_vld   = 1'b0;
    i_clear = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_prbs(input int n, input int gap);
    logic b;
    for (int i = 0; i < n; i++) begin
      prbs_next(b);
      send_bit(b, 1'b0, gap);
    end
  endtask

  // One idle cycle so a final o_win_vld pulse is seen by the monitor.
  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Fresh search must lock on exactly the 79th clean bit (15 fill + 64 matches).
  task automatic relock(input string tag, input int tot_bits_before);
    send_prbs(78, 0);
    check({tag, " locked after 78"}, 64'(o_locked), 64'd0);
    check({tag, " tot_bits held"}, 64'(o_tot_bits), 64'(tot_bits_before));
    send_prbs(1, 0);
    check({tag, " locked after 79"}, 64'(o_locked), 64'd1);
    check({tag, " tot_bits at lock"}, 64'(o_tot_bits), 64'd0);
    check({tag, " tot_err at lock"}, 64'(o_tot_err), 64'd0);
  endtask

  task automatic run_row(input int idx);
    row_t r;
    logic b;
    int   p0;
    r = rows[idx];
    if (r.rst_first) do_reset();
    p0 = pulses;
    for (int i = 0; i < r.nbits; i++) begin
      prbs_next(b);
      case (r.mode)
        1: if (i % 128 == 0) b = ~b;
        2: if (i % 2 == 1) b = ~b;
        3: b = ~b;
        default: ;
      endcase
      send_bit(b, 1'b0, r.gap);
    end
    idle();
    check($sformatf("row%0d locked", idx), 64'(o_locked), 64'(r.exp_locked));
    check($sformatf("row%0d win pulses", idx), 64'(pulses - p0), 64'(r.exp_pulses));
    check($sformatf("row%0d win_err", idx), 64'(o_win_err), 64'(r.exp_win_err));
    check($sformatf("row%0d tot_bits", idx), 64'(o_tot_bits), 64'(r.exp_tot_bits));
    check($sformatf("row%0d tot_err", idx), 64'(o_tot_err), 64'(r.exp_tot_err));
  endtask

  initial begin
    logic b;
    int   p0;

    rows[0] = '{mode: 0, nbits: 2048, gap: 0,  rst_first: 1'b0, exp_locked: 1'b1,
                exp_pulses: 2, exp_win_err: 0, exp_tot_bits: 2048, exp_tot_err: 0};
    rows[1] = '{mode: 1, nbits: 2048, gap: 0,  rst_first: 1'b0, exp_locked: 1'b1,
                exp_pulses: 2, exp_win_err: 8, exp_tot_bits: 4096, exp_tot_err: 16};
    rows[2] = '{mode: 2, nbits: 1024, gap: 0,  rst_first: 1'b0, exp_locked: 1'b0,
                exp_pulses: 1, exp_win_err: 512, exp_tot_bits: 5120, exp_tot_err: 528};
    rows[3] = '{mode: 0, nbits: 1024, gap: 63, rst_first: 1'b0, exp_locked: 1'b1,
                exp_pulses: 1, exp_win_err: 0, exp_tot_bits: 1024, exp_tot_err: 0};
    rows[4] = '{mode: 3, nbits: 5000, gap: 0,  rst_first: 1'b1, exp_locked: 1'b0,
                exp_pulses: 0, exp_win_err: 0, exp_tot_bits: 0, exp_tot_err: 0};

    reset   = 1'b1;
    i_clear = 1'b0;
    i_vld   = 1'b0;
    i_sym   = 1'b0;
    #12;
    check("reset locked", 64'(o_locked), 64'd0);
    check("reset win_vld", 64'(o_win_vld), 64'd0);
    check("reset win_err", 64'(o_win_err), 64'd0);
    check("reset tot_err", 64'(o_tot_err), 64'd0);
    check("reset tot_bits", 64'(o_tot_bits), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    relock("initial", 0);

    // Dense clean, sparse errors, then a 512-error window that drops lock.
    for (int i = 0; i < 3; i++) run_row(i);

    // Totals hold until relock; relock then restarts them.
    relock("after loss", 5120);

    // Sparse one-in-64 strobe, clean stream.
    run_row(3);

    // Clear coincident with the window-end bit.
    send_prbs(1023, 0);
    check("pre-clear tot_bits", 64'(o_tot_bits), 64'd2047);
    p0 = pulses;
    prbs_next(b);
    send_bit(b, 1'b1, 0);
    check("clear win_vld", 64'(o_win_vld), 64'd0);
    idle();
    check("clear no pulse", 64'(pulses - p0), 64'd0);
    check("clear tot_bits", 64'(o_tot_bits), 64'd0);
    check("clear tot_err", 64'(o_tot_err), 64'd0);
    check("clear win_err", 64'(o_win_err), 64'd0);
    check("clear locked", 64'(o_locked), 64'd1);
    send_prbs(1024, 0);
    idle();
    check("post-clear pulse", 64'(pulses - p0), 64'd1);
    check("post-clear tot_bits", 64'(o_tot_bits), 64'd1024);

    // Asynchronous reset mid-window: outputs drop before any clock edge.
    send_prbs(300, 0);
    check("pre-reset tot_bits", 64'(o_tot_bits), 64'd1324);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async reset locked", 64'(o_locked), 64'd0);
    check("async reset tot_bits", 64'(o_tot_bits), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    relock("after reset", 0);

    // Inverted stream from reset never locks.
    run_row(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
